display_scan_ctrl: RTL and testbench



---
 rtl/display_pkg.sv | 46 ++++
 rtl/hex7seg.sv | 11 +
 rtl/display_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and the hex-to-segment font for the seven-segment display blocks.
// Segment order is {dp,g,f,e,d,c,b,a}, active-high.
package display_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;
    localparam int CODE_W     = 3;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    function automatic logic [6:0] hex_font(input logic [DIGIT_W-1:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to seven-segment encoder ({g,f,e,d,c,b,a}, active-high).
module hex7seg
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    assign seg = hex_font(digit);

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit seven-segment scan controller with a double-buffered frame (pending buffer + shadow).
// Define DISPLAY_LZB_EN to enable leading-zero blanking.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          wr_valid,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] wr_digits,
    input  logic [NUM_DIGITS-1:0]         wr_dp,
    output logic [CODE_W-1:0]             code,
    output logic [7:0]                    seg,
    output logic                          frame_done,
    output logic                          pending
);

    localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = NUM_DIGITS * DIGIT_W;
    localparam logic [PRE_W-1:0]  PRE_MAX    = PRE_W'(SCAN_DIV - 1);
    localparam logic [CODE_W-1:0] CODE_FIRST = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_LAST  = CODE_W'(NUM_DIGITS);

    scan_state_t          state, state_nxt;
    logic [PRE_W-1:0]     presc, presc_nxt;
    logic [CODE_W-1:0]    code_nxt;
    logic                 tick, boundary, fd_nxt, pending_nxt;
    logic [FRAME_W-1:0]   pnd_digits, pnd_digits_nxt, shd_digits, shd_digits_nxt;
    logic [NUM_DIGITS-1:0] pnd_dp, pnd_dp_nxt, shd_dp, shd_dp_nxt, blank;
    logic [DIGIT_W-1:0]   sel_digit;
    logic                 sel_dp, sel_blank;
    logic [6:0]           font;
    logic [7:0]           seg_nxt;

    assign tick = (state == ST_SCAN) && (presc == PRE_MAX);

    // Scan sequencing; the IDLE->SCAN step counts as a frame boundary but not a frame end
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        presc_nxt = presc;
        boundary  = 1'b0;
        fd_nxt    = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
            code_nxt  = '0;
            presc_nxt = '0;
        end else if (state == ST_IDLE) begin
            state_nxt = ST_SCAN;
            code_nxt  = CODE_FIRST;
            presc_nxt = '0;
            boundary  = 1'b1;
        end else if (tick) begin
            presc_nxt = '0;
            if (code == CODE_LAST) begin
                code_nxt = CODE_FIRST;
                boundary = 1'b1;
                fd_nxt   = 1'b1;
            end else begin
                code_nxt = code + 1'b1;
            end
        end else begin
            presc_nxt = presc + 1'b1;
        end
    end

    // A write landing on a boundary stays in the buffer; the shadow takes the older contents
    always_comb begin
        shd_digits_nxt = shd_digits;
        shd_dp_nxt     = shd_dp;
        if (boundary && pending) begin
            shd_digits_nxt = pnd_digits;
            shd_dp_nxt     = pnd_dp;
        end
        pnd_digits_nxt = pnd_digits;
        pnd_dp_nxt     = pnd_dp;
        pending_nxt    = pending;
        if (wr_valid) begin
            pnd_digits_nxt = wr_digits;
            pnd_dp_nxt     = wr_dp;
            pending_nxt    = 1'b1;
        end else if (boundary) begin
            pending_nxt = 1'b0;
        end
    end

`ifdef DISPLAY_LZB_EN
    // A digit blanks only if it and every higher digit are zero with dp clear; digit 1 always shows
    always_comb begin
        logic run;
        run   = 1'b1;
        blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run = run && (shd_digits_nxt[k*DIGIT_W +: DIGIT_W] == '0) && !shd_dp_nxt[k];
            blank[k] = run;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        sel_digit = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (code_nxt == CODE_W'(k + 1)) begin
                sel_digit = shd_digits_nxt[k*DIGIT_W +: DIGIT_W];
                sel_dp    = shd_dp_nxt[k];
                sel_blank = blank[k];
            end
        end
    end

    hex7seg u_hex7seg (
        .digit (sel_digit),
        .seg   (font)
    );

    always_comb begin
        seg_nxt = '0;
        if ((code_nxt != '0) && !sel_blank) begin
            seg_nxt[SEG_G:SEG_A] = font;
            seg_nxt[SEG_DP]      = sel_dp;
        end
    end

    // Registered outputs: code and seg update together from the same next-state view
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            presc      <= '0;
            code       <= '0;
            seg        <= '0;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            pnd_digits <= '0;
            pnd_dp     <= '0;
            shd_digits <= '0;
            shd_dp     <= '0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            code       <= code_nxt;
            seg        <= seg_nxt;
            frame_done <= fd_nxt;
            pending    <= pending_nxt;
            pnd_digits <= pnd_digits_nxt;
            pnd_dp     <= pnd_dp_nxt;
            shd_digits <= shd_digits_nxt;
            shd_dp     <= shd_dp_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a time-based frame model predicts every cycle's outputs.
// Blanking expectations follow DISPLAY_LZB_EN.
module tb_display_scan_ctrl;

    localparam int D = 4;
    localparam int FRAME = 6 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b0, wr_valid = 1'b0;
    logic [23:0] wr_digits = '0;
    logic [5:0]  wr_dp = '0;
    logic [2:0]  code;
    logic [7:0]  seg;
    logic        frame_done, pending;

    display_scan_ctrl #(.SCAN_DIV(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_valid   (wr_valid),
        .wr_digits  (wr_digits),
        .wr_dp      (wr_dp),
        .code       (code),
        .seg        (seg),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] code;
        logic [7:0] seg;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t q[$];

    // Reference model: scan position is simply cycles elapsed since scanning began
    bit       m_scan = 0;
    int       m_t = 0;
    bit       m_pend = 0;
    logic [3:0] m_bufd[6];
    logic [3:0] m_shdd[6];
    bit       m_bufp[6];
    bit       m_shdp[6];

    function automatic logic [6:0] ref_font(input logic [3:0] v);
        logic [6:0] t[16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    function automatic bit ref_blank(input int k);
        bit b;
        b = (k > 1);
`ifdef DISPLAY_LZB_EN
        for (int j = k; j <= 6; j++)
            if (m_shdd[j-1] != 4'h0 || m_shdp[j-1]) b = 0;
`else
        b = 0;
`endif
        return b;
    endfunction

    function automatic void model_step(input bit r, input bit e, input bit w,
                                       input logic [23:0] d, input logic [5:0] dp);
        bit bnd;
        if (r) begin
            m_scan = 0; m_t = 0; m_pend = 0;
            for (int i = 0; i < 6; i++) begin
                m_bufd[i] = 0; m_shdd[i] = 0; m_bufp[i] = 0; m_shdp[i] = 0;
            end
        end else begin
            bnd = e && (!m_scan || ((m_t + 1) % FRAME == 0));
            if (bnd && m_pend)
                for (int i = 0; i < 6; i++) begin
                    m_shdd[i] = m_bufd[i]; m_shdp[i] = m_bufp[i];
                end
            if (w) begin
                for (int i = 0; i < 6; i++) begin
                    m_bufd[i] = d[4*i +: 4]; m_bufp[i] = dp[i];
                end
                m_pend = 1;
            end else if (bnd) begin
                m_pend = 0;
            end
            if (!e) m_scan = 0;
            else if (!m_scan) begin m_scan = 1; m_t = 0; end
            else m_t++;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t x;
        int k;
        k = m_scan ? 1 + (m_t / D) % 6 : 0;
        x.code = 3'(k);
        x.seg  = 8'h00;
        if (k != 0 && !ref_blank(k)) x.seg = {m_shdp[k-1], ref_font(m_shdd[k-1])};
        x.fd   = m_scan && (m_t > 0) && (m_t % FRAME == 0);
        x.pend = m_pend;
        return x;
    endfunction

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: one expected record per clock edge
    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (q.size() > 0) begin
            ex = q.pop_front();
            chk("code", {5'b0, code}, {5'b0, ex.code});
            chk("seg", seg, ex.seg);
            chk("frame_done", {7'b0, frame_done}, {7'b0, ex.fd});
            chk("pending", {7'b0, pending}, {7'b0, ex.pend});
        end
    end

    task automatic cyc(input bit r, input bit e, input bit w,
                       input logic [23:0] d, input logic [5:0] dp);
        @(negedge clk);
        rst = r; en = e; wr_valid = w; wr_digits = d; wr_dp = dp;
        model_step(r, e, w, d, dp);
        q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic wait_code(input logic [2:0] c);
        int n;
        n = 0;
        while (code !== c && n < 200) begin
            cyc(0, 1, 0, 24'h0, 6'h0);
            n++;
        end
        if (code !== c) begin
            checks++;
            errors++;
            $display("FAIL wait_code: code %0d never reached %0d", code, c);
        end
    endtask

    function automatic int steps_to_boundary();
        return (FRAME - 1) - (m_t % FRAME);
    endfunction

    initial begin
        bit          cur_en;
        logic [23:0] rd;
        int          guard;

        cyc(1, 0, 0, 24'h0, 6'h0);
        cyc(1, 0, 0, 24'h0, 6'h0);
        chk("reset_code", {5'b0, code}, 8'h00);
        chk("reset_seg", seg, 8'h00);
        chk("reset_pending", {7'b0, pending}, 8'h00);
        for (int i = 0; i < 56; i++) cyc(0, 1, 0, 24'h0, 6'h0);

        // Font and decimal point
        cyc(0, 1, 1, 24'hFEDCBA, 6'b000001);
        wait_code(1);
        chk("font_A_dp", seg, 8'hF7);
        wait_code(6);
        chk("font_F", seg, 8'h71);

        // No tearing: zeros displayed, then ones written mid-frame
        cyc(0, 1, 1, 24'h000000, 6'h0);
        wait_code(1);
        wait_code(3);
        chk("zeros_shown", seg, 8'h3F);
        cyc(0, 1, 1, 24'h111111, 6'h0);
        chk("tear_pending", {7'b0, pending}, 8'h01);
        chk("tear_hold", seg, 8'h3F);
        wait_code(1);
        chk("tear_ones", seg, 8'h06);
        chk("tear_pending_clr", {7'b0, pending}, 8'h00);

        // Boundary collision: A two cycles before the code-6 tick, B on the tick
        guard = 0;
        while (steps_to_boundary() != 2 && guard < 100) begin
            cyc(0, 1, 0, 24'h0, 6'h0);
            guard++;
        end
        cyc(0, 1, 1, 24'h333333, 6'h0);
        cyc(0, 1, 0, 24'h0, 6'h0);
        cyc(0, 1, 1, 24'h555555, 6'h0);
        chk("coll_code", {5'b0, code}, 8'h01);
        chk("coll_A_shown", seg, 8'h4F);
        chk("coll_pending", {7'b0, pending}, 8'h01);
        wait_code(6);
        wait_code(1);
        chk("coll_B_shown", seg, 8'h6D);

        // en toggle at code 3
        wait_code(3);
        cyc(0, 0, 0, 24'h0, 6'h0);
        chk("en_off_code", {5'b0, code}, 8'h00);
        chk("en_off_seg", seg, 8'h00);
        cyc(0, 1, 0, 24'h0, 6'h0);
        chk("en_on_code", {5'b0, code}, 8'h01);
        chk("en_on_fd", {7'b0, frame_done}, 8'h00);

        // Leading-zero blanking
        cyc(0, 1, 1, 24'h000120, 6'h0);
        wait_code(6);
        wait_code(1);
        chk("lzb_d1", seg, 8'h3F);
        wait_code(2);
        chk("lzb_d2", seg, 8'h5B);
        wait_code(3);
        chk("lzb_d3", seg, 8'h06);
        wait_code(4);
`ifdef DISPLAY_LZB_EN
        chk("lzb_d4", seg, 8'h00);
`else
        chk("lzb_d4", seg, 8'h3F);
`endif
        wait_code(6);
`ifdef DISPLAY_LZB_EN
        chk("lzb_d6", seg, 8'h00);
`else
        chk("lzb_d6", seg, 8'h3F);
`endif

        // Randomized traffic against the model
        cur_en = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 2) cur_en = !cur_en;
            rd = 24'($urandom);
            if ($urandom_range(0, 1) == 1) rd = rd >> (4 * $urandom_range(1, 6));
            cyc(($urandom_range(0, 299) == 0), cur_en, ($urandom_range(0, 99) < 8),
                rd, 6'($urandom_range(0, 3) == 0 ? $urandom : 0));
        end

        // rst mid-scan with a pending write, with priority over en and wr_valid
        cyc(0, 1, 1, 24'h999999, 6'h3F);
        cyc(1, 1, 1, 24'h888888, 6'h3F);
        chk("rst_code", {5'b0, code}, 8'h00);
        chk("rst_pending", {7'b0, pending}, 8'h00);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 24'h0, 6'h0);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected records left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
